trace_capture_buffer: RTL and testbench

Next-generation trace buffer for the NoC debug infrastructure. It merges source selection and trace storage into one block, and adds arm/trigger control with configurable post-trigger capture. It supports linear or circular (pre-trigger history) modes and a handshaked, oldest-first readout port for the JTAG/debug host. It sits between the per-router trace taps and the debug access port, and stores data in a single inferred simple-dual-port BRAM.

---
 rtl/trace_capture_buffer.sv | 194 +++++++++++++++++++
 tb/tb_trace_capture_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer.sv
// Trace capture buffer: selects one trace channel, stores it in a BRAM
// under arm/trigger control, then replays it oldest-first to the host.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   ch_din, ch_wr         per-channel trace words and write strobes
//   ch_sel, mode          source channel and capture mode (sampled on arm)
//   arm, trigger          start capture / trigger event (mode 1)
//   post_count            post-trigger writes (sampled on arm, clamped)
//   rd_req                pop one stored word
//   rd_valid/data/last    readout word, one cycle after its rd_req
//   count, wrapped, done  fill level, overwrite flag, capture frozen
//   state                 IDLE=0 ARMED=1 POST=2 DONE=3 READ=4
module trace_capture_buffer #(
   parameter  int Fpay     = 32,
   parameter  int NCH      = 5,
   parameter  int TB_DEPTH = 512,
   localparam int AW       = $clog2(TB_DEPTH),
   localparam int SW       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH*Fpay-1:0] ch_din,
   input  logic [NCH-1:0]    ch_wr,
   input  logic [SW-1:0]     ch_sel,
   input  logic              mode,
   input  logic              arm,
   input  logic              trigger,
   input  logic [AW:0]       post_count,
   input  logic              rd_req,
   output logic              rd_valid,
   output logic [Fpay-1:0]   rd_data,
   output logic              rd_last,
   output logic [AW:0]       count,
   output logic              wrapped,
   output logic              done,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      POST  = 3'd2,
      DONE  = 3'd3,
      READ  = 3'd4
   } state_t;

   localparam logic [AW:0]   DEPTH_C = (AW+1)'(TB_DEPTH);
   localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
   localparam logic [SW-1:0] LAST_CH = SW'(NCH - 1);

   state_t          state_q, state_d;
   logic [SW-1:0]   sel_q, sel_clamp;
   logic            mode_q;
   logic [AW:0]     post_q, post_clamp, post_rem, rd_rem, count_q;
   logic [AW-1:0]   wr_ptr, rd_ptr, rd_addr;
   logic [Fpay-1:0] wr_word, mem_rd;
   logic            wr_bit, wr_fire;
   logic            rd_start, rd_step, rd_fire, rd_is_last, rd_seen;
   logic [Fpay-1:0] mem [TB_DEPTH];

   assign sel_clamp  = (32'(ch_sel) >= 32'(NCH)) ? LAST_CH : ch_sel;
   assign post_clamp = (post_count > DEPTH_C) ? DEPTH_C : post_count;

   always_comb begin
      wr_word = '0;
      wr_bit  = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (sel_q == SW'(k)) begin
            wr_word = ch_din[k*Fpay +: Fpay];
            wr_bit  = ch_wr[k];
         end
      end
   end

   // arm takes priority over any capture or readout activity
   assign wr_fire = (state_q == ARMED || state_q == POST)
                    && wr_bit && !arm;
   assign rd_start = (state_q == DONE) && rd_req
                     && (count_q != '0) && !arm;
   assign rd_step = (state_q == READ) && rd_req
                    && (rd_rem != '0) && !arm;
   assign rd_fire = rd_start | rd_step;

   // a full buffer starts at the oldest entry, which is the next write slot
   assign rd_addr = rd_start
                    ? ((count_q == DEPTH_C) ? wr_ptr : '0)
                    : rd_ptr;
   assign rd_is_last = rd_start ? (count_q == ONE_C)
                                : (rd_rem == ONE_C);

   always_ff @(posedge clk) begin
      if (wr_fire)
         mem[wr_ptr] <= wr_word;
      if (rd_fire)
         mem_rd <= mem[rd_addr];
   end

   // keeps the BRAM output register reset-free while rd_data still
   // reads zero until the first word after reset
   assign rd_data = rd_seen ? mem_rd : '0;
   assign count   = count_q;
   assign done    = (state_q == DONE) || (state_q == READ);
   assign state   = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (arm) begin
         state_d = ARMED;
      end else begin
         unique case (state_q)
            IDLE: state_d = IDLE;
            ARMED: begin
               if (!mode_q) begin
                  if (wr_fire && count_q == DEPTH_C - ONE_C)
                     state_d = DONE;
               end else if (trigger) begin
                  state_d = (post_q == '0) ? DONE : POST;
               end
            end
            POST: begin
               if (wr_fire && post_rem == ONE_C)
                  state_d = DONE;
            end
            DONE: begin
               if (rd_start)
                  state_d = READ;
            end
            READ: begin
               if (rd_rem == '0)
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_q    <= '0;
         mode_q   <= 1'b0;
         post_q   <= '0;
         post_rem <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_rem   <= '0;
         count_q  <= '0;
         wrapped  <= 1'b0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_seen  <= 1'b0;
      end else begin
         rd_valid <= rd_fire;
         rd_last  <= rd_fire && rd_is_last;
         if (arm) begin
            sel_q    <= sel_clamp;
            mode_q   <= mode;
            post_q   <= post_clamp;
            post_rem <= '0;
            wr_ptr   <= '0;
            rd_rem   <= '0;
            count_q  <= '0;
            wrapped  <= 1'b0;
         end
         if (wr_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count_q == DEPTH_C)
               wrapped <= 1'b1;
            else
               count_q <= count_q + ONE_C;
            if (state_q == POST)
               post_rem <= post_rem - ONE_C;
         end
         // a write in the trigger cycle is pre-trigger: post_rem not touched
         if (state_q == ARMED && mode_q && trigger && !arm)
            post_rem <= post_q;
         if (rd_fire) begin
            rd_seen <= 1'b1;
            rd_ptr  <= rd_addr + 1'b1;
            rd_rem  <= (rd_start ? count_q : rd_rem) - ONE_C;
         end
         if (state_q == READ && rd_rem == '0 && !arm)
            count_q <= '0;
      end
   end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Bench for trace_capture_buffer: directed scenarios plus random sessions
// compared cycle by cycle against a queue-based reference model.
module tb_trace_capture_buffer;

   localparam int FPAY  = 32;
   localparam int NCH   = 5;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int SW    = 3;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NCH*FPAY-1:0]   ch_din;
   logic [NCH-1:0]        ch_wr;
   logic [SW-1:0]         ch_sel;
   logic                  mode, arm, trigger, rd_req;
   logic [AW:0]           post_count;
   logic                  rd_valid, rd_last, wrapped, done;
   logic [FPAY-1:0]       rd_data;
   logic [AW:0]           count;
   logic [2:0]            state;

   trace_capture_buffer #(
      .Fpay(FPAY), .NCH(NCH), .TB_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .ch_din(ch_din), .ch_wr(ch_wr),
      .ch_sel(ch_sel), .mode(mode), .arm(arm), .trigger(trigger),
      .post_count(post_count), .rd_req(rd_req), .rd_valid(rd_valid),
      .rd_data(rd_data), .rd_last(rd_last), .count(count),
      .wrapped(wrapped), .done(done), .state(state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // reference model: capture is a bounded queue, readout a copy of it
   int          m_state, m_sel, m_post, m_prem;
   bit          m_mode, m_wrapped, m_valid, m_last;
   logic [31:0] m_data;
   logic [31:0] m_q[$];
   logic [31:0] m_rq[$];

   task automatic m_push(input logic [31:0] w);
      m_q.push_back(w);
      if (m_q.size() > DEPTH) begin
         void'(m_q.pop_front());
         m_wrapped = 1'b1;
      end
   endtask

   always @(posedge clk or posedge reset) begin : model
      bit          wr, nv, nl;
      logic [31:0] w;
      if (reset) begin
         m_state = 0; m_sel = 0; m_post = 0; m_prem = 0; m_mode = 0;
         m_wrapped = 0; m_valid = 0; m_last = 0; m_data = '0;
         m_q.delete(); m_rq.delete();
      end else begin
         wr = (m_state == 1 || m_state == 2) && ch_wr[m_sel] && !arm;
         w  = ch_din[m_sel*FPAY +: FPAY];
         nv = 0; nl = 0;
         if (arm) begin
            m_sel  = (int'(ch_sel) >= NCH) ? NCH - 1 : int'(ch_sel);
            m_mode = mode;
            m_post = (int'(post_count) > DEPTH) ? DEPTH : int'(post_count);
            m_q.delete(); m_rq.delete();
            m_wrapped = 0;
            m_state = 1;
         end else begin
            case (m_state)
               1: begin
                  if (wr) m_push(w);
                  if (!m_mode) begin
                     if (m_q.size() == DEPTH) m_state = 3;
                  end else if (trigger) begin
                     m_prem  = m_post;
                     m_state = (m_post == 0) ? 3 : 2;
                  end
               end
               2: if (wr) begin
                  m_push(w);
                  m_prem--;
                  if (m_prem == 0) m_state = 3;
               end
               3: if (rd_req && m_q.size() > 0) begin
                  m_rq = m_q;
                  m_data = m_rq.pop_front();
                  nv = 1; nl = (m_rq.size() == 0);
                  m_state = 4;
               end
               4: if (m_rq.size() == 0) begin
                  m_state = 0;
                  m_q.delete();
               end else if (rd_req) begin
                  m_data = m_rq.pop_front();
                  nv = 1; nl = (m_rq.size() == 0);
               end
               default: ;
            endcase
         end
         m_valid = nv;
         m_last  = nl;
      end
   end

   bit          chk_en = 0;
   logic [31:0] rlog[$];
   int          last_idx[$];

   always @(negedge clk) begin
      if (chk_en && !reset) begin
         chk("state", state, m_state);
         chk("count", count, m_q.size());
         chk("wrapped", wrapped, m_wrapped);
         chk("done", done, (m_state == 3 || m_state == 4));
         chk("rd_valid", rd_valid, m_valid);
         chk("rd_last", rd_last, m_last);
         chk("rd_data", rd_data, m_data);
         if (rd_valid) begin
            rlog.push_back(rd_data);
            if (rd_last) last_idx.push_back(rlog.size() - 1);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic idle_in();
      ch_wr = '0; arm = 0; trigger = 0; rd_req = 0;
   endtask

   task automatic set_ch(input int k, input logic [31:0] v);
      ch_din[k*FPAY +: FPAY] = v;
   endtask

   task automatic do_arm(input int sel, input bit md, input int pc);
      ch_sel = SW'(sel); mode = md; post_count = (AW+1)'(pc);
      arm = 1; step(); arm = 0;
   endtask

   task automatic wr1(input int k, input logic [31:0] v, input bit trg);
      ch_wr = '0; ch_wr[k] = 1'b1; set_ch(k, v); trigger = trg;
      step();
      ch_wr = '0; trigger = 0;
   endtask

   task automatic read_n(input int n);
      rlog.delete(); last_idx.delete();
      rd_req = 1; step(n); rd_req = 0; step(3);
   endtask

   task automatic chk_log(input string name, input logic [31:0] base,
                          input int n);
      chk({name, "_len"}, rlog.size(), n);
      for (int i = 0; i < n && i < rlog.size(); i++)
         chk({name, "_word"}, rlog[i], base + 32'(i));
      chk({name, "_last"}, (last_idx.size() == 1) ? last_idx[0] : -1,
          n - 1);
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, "_state"}, state, 0);
      chk({name, "_count"}, count, 0);
      chk({name, "_wrapped"}, wrapped, 0);
      chk({name, "_done"}, done, 0);
      chk({name, "_rd_valid"}, rd_valid, 0);
      chk({name, "_rd_last"}, rd_last, 0);
      chk({name, "_rd_data"}, rd_data, 0);
   endtask

   initial begin
      reset = 1; idle_in(); ch_din = '0; ch_sel = '0;
      mode = 0; post_count = '0;
      step(2);
      chk_reset_vals("por");
      reset = 0; chk_en = 1;
      step();

      // linear capture stops when full, unselected strobes ignored
      do_arm(2, 0, 0);
      for (int i = 0; i < 10; i++) begin
         ch_wr = 5'b00101;
         set_ch(2, 32'h100 + 32'(i));
         set_ch(0, 32'hdead0000 + 32'(i));
         step();
      end
      ch_wr = '0; step();
      chk("t1_state", state, 3);
      chk("t1_count", count, 8);
      chk("t1_wrapped", wrapped, 0);
      read_n(9);
      chk_log("t1", 32'h100, 8);
      chk("t1_idle", state, 0);

      // circular capture with post-trigger window
      do_arm(0, 1, 3);
      for (int i = 0; i < 12; i++) wr1(0, 32'(i), i == 8);
      step();
      chk("t2_state", state, 3);
      chk("t2_wrapped", wrapped, 1);
      chk("t2_count", count, 8);
      read_n(8);
      chk_log("t2", 32'h4, 8);

      // zero post count: trigger freezes immediately
      do_arm(1, 1, 0);
      wr1(1, 32'ha, 0); wr1(1, 32'hb, 0); wr1(1, 32'hc, 0);
      trigger = 1; step(); trigger = 0;
      chk("t3_state", state, 3);
      chk("t3_count", count, 3);
      read_n(3);
      chk_log("t3", 32'ha, 3);

      // async reset in POST
      do_arm(3, 1, 5);
      wr1(3, 32'h30, 0); wr1(3, 32'h31, 0); wr1(3, 32'h32, 1);
      wr1(3, 32'h33, 0); wr1(3, 32'h34, 0);
      chk("t5a_post", state, 2);
      reset = 1; #1;
      chk_reset_vals("rst_post");
      step(); reset = 0; step();
      do_arm(3, 1, 0);
      wr1(3, 32'h50, 0); wr1(3, 32'h51, 0);
      trigger = 1; step(); trigger = 0;
      read_n(2);
      chk_log("t5a", 32'h50, 2);

      // async reset in READ with a word on the output
      do_arm(0, 1, 0);
      for (int i = 0; i < 4; i++) wr1(0, 32'h40 + 32'(i), i == 3);
      rd_req = 1; step(2); rd_req = 0;
      chk("t5b_valid", rd_valid, 1);
      reset = 1; #1;
      chk_reset_vals("rst_read");
      step(); reset = 0; step();
      do_arm(0, 1, 0);
      for (int i = 0; i < 3; i++) wr1(0, 32'h60 + 32'(i), i == 2);
      read_n(3);
      chk_log("t5b", 32'h60, 3);

      // out-of-range select clamps to last channel; arm aborts readout
      do_arm(7, 1, 0);
      for (int i = 0; i < 5; i++) begin
         ch_wr = 5'b11111;
         for (int k = 0; k < NCH; k++)
            set_ch(k, 32'h1000 * 32'(k) + 32'(i));
         trigger = (i == 4);
         step();
      end
      ch_wr = '0; trigger = 0;
      chk("t6_count", count, 5);
      rlog.delete(); last_idx.delete();
      rd_req = 1; step(2); rd_req = 0; step();
      arm = 1; step(); arm = 0;
      chk("t6_state", state, 1);
      chk("t6_count0", count, 0);
      rd_req = 1; step(3); rd_req = 0;
      chk("t6_len", rlog.size(), 2);
      if (rlog.size() == 2) begin
         chk("t6_w0", rlog[0], 32'h4000);
         chk("t6_w1", rlog[1], 32'h4001);
      end

      // random sessions
      for (int s = 0; s < 40; s++) begin
         do_arm($urandom_range(0, 7), 1'($urandom_range(0, 1)),
                $urandom_range(0, 15));
         for (int c = 0; c < 60; c++) begin
            ch_wr = NCH'($urandom);
            for (int k = 0; k < NCH; k++) set_ch(k, $urandom);
            trigger = ($urandom_range(0, 9) == 0);
            rd_req = (c > 30) ? ($urandom_range(0, 3) != 0)
                              : ($urandom_range(0, 5) == 0);
            arm = ($urandom_range(0, 99) == 0);
            ch_sel = SW'($urandom_range(0, 7));
            post_count = (AW+1)'($urandom_range(0, 15));
            step();
         end
         idle_in();
         step();
      end

      idle_in();
      step(2);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
